// File: rtl/tt_serial_pkg.sv
// Shared constants and state encoding for the bit-serial adder tile.
package tt_serial_pkg;

    localparam int unsigned WIDTH = 8;
    localparam logic [7:0] UIO_OE_MASK = 8'b0011_1000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/tt_um_serial_adder_if.sv
// TinyTapeout pad bundle; the master side drives operands and strobes.
interface tt_um_serial_adder_if;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (output ui_in, uio_in, input uo_out, uio_out, uio_oe);
    modport slave  (input ui_in, uio_in, output uo_out, uio_out, uio_oe);
endinterface

// File: rtl/ha_cell.sv
// Half-adder cell; two of these plus an OR make the serial full adder.
module ha_cell (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);
    assign s = a ^ b;
    assign c = a & b;
endmodule

// File: rtl/tt_um_serial_adder.sv
// Bit-serial 8-bit adder: loads operands, shifts them LSB first through a full
// adder built from two half-adder cells, and presents the parallel result.
module tt_um_serial_adder
    import tt_serial_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    state_e             state_q, state_d;
    logic [2:0]         strb_q;
    logic [WIDTH-1:0]   a_sr_q, a_sr_d;
    logic [WIDTH-1:0]   b_sr_q, b_sr_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;

    logic pulse_a, pulse_b, pulse_start, any_load;
    logic hs0, hc0, s_bit, hc1, carry_new;
    logic busy, done;

    logic unused_pins;
    assign unused_pins = ^{ena, uio_in[7:3]};

    assign pulse_a     = uio_in[0] & ~strb_q[0];
    assign pulse_b     = uio_in[1] & ~strb_q[1];
    assign pulse_start = uio_in[2] & ~strb_q[2];
    assign any_load    = pulse_a | pulse_b;

    ha_cell u_ha_ab (
        .a (a_sr_q[0]),
        .b (b_sr_q[0]),
        .s (hs0),
        .c (hc0)
    );

    ha_cell u_ha_cin (
        .a (hs0),
        .b (carry_q),
        .s (s_bit),
        .c (hc1)
    );

    assign carry_new = hc0 | hc1;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath and edge-detect registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            strb_q  <= '0;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            acc_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
        end else begin
            strb_q  <= uio_in[2:0];
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            acc_q   <= acc_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
        end
    end

    // Next-state and datapath updates
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        acc_d   = acc_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        cout_d  = cout_q;

        unique case (state_q)
            ST_RUN: begin
                carry_d = carry_new;
                acc_d   = {s_bit, acc_q[WIDTH-1:1]};
                a_sr_d  = {1'b0, a_sr_q[WIDTH-1:1]};
                b_sr_d  = {1'b0, b_sr_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = ST_DONE;
                    sum_d   = {s_bit, acc_q[WIDTH-1:1]};
                    cout_d  = carry_new;
                end
            end
            default: begin
                if (pulse_a) a_sr_d = ui_in;
                if (pulse_b) b_sr_d = ui_in;
                // A load in the same cycle as start wins; start is dropped.
                if (any_load) begin
                    state_d = ST_IDLE;
                end else if (pulse_start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                    carry_d = 1'b0;
                    acc_d   = '0;
                end
            end
        endcase
    end

    // Outputs
    always_comb begin
        busy    = (state_q == ST_RUN);
        done    = (state_q == ST_DONE);
        uo_out  = sum_q;
        uio_out = {2'b00, cout_q, done, busy, 3'b000};
        uio_oe  = UIO_OE_MASK;
    end

endmodule
